// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_A = 2'd1,
    ST_SERVE_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Maps a requester side onto the state that serves it.
  function automatic state_e serve_state(input logic side);
    return (side == SEL_B) ? ST_SERVE_B : ST_SERVE_A;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Request/data inputs from the two producers plus the shared downstream channel.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 4
);

  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  out_valid, out_data, gnt_a, gnt_b, sel
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output out_valid, out_data, gnt_a, gnt_b, sel
  );

endinterface

// File: rtl/mux2_rr_arbiter_mux21_w.sv
// Parameterized 2:1 combinational mux; sel_i=0 picks a_i, sel_i=1 picks b_i.
module mux21_w #(
  parameter int WIDTH = 4
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one 2:1 mux between requesters A and B.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux2_rr_arbiter_if.slave  bus
);

  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          sel_q;
  logic          gnt_a_q;
  logic          gnt_b_q;

  logic          own_side_s;
  logic          req_own_s;
  logic          req_oth_s;
  logic          out_valid_s;
  logic          xfer_s;

  assign own_side_s  = (state_q == ST_SERVE_B) ? SEL_B : SEL_A;
  assign req_own_s   = (own_side_s == SEL_B) ? bus.req_b : bus.req_a;
  assign req_oth_s   = (own_side_s == SEL_B) ? bus.req_a : bus.req_b;
  assign out_valid_s = (gnt_a_q & bus.req_a) | (gnt_b_q & bus.req_b);
  assign xfer_s      = out_valid_s & bus.out_ready;

  // Next-state, burst count and last-served side.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (bus.req_a && bus.req_b) begin
          state_d = serve_state(~last_q);
        end else if (bus.req_a) begin
          state_d = ST_SERVE_A;
        end else if (bus.req_b) begin
          state_d = ST_SERVE_B;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE_A, ST_SERVE_B: begin
        if (!req_own_s) begin
          // Owner released (with or without a transfer): hand over or go idle.
          state_d = req_oth_s ? serve_state(~own_side_s) : ST_IDLE;
          cnt_d   = CNT_ZERO;
          last_d  = own_side_s;
        end else if (xfer_s) begin
          if (cnt_q == CNT_LAST) begin
            // Saturate while uncontended so an unopposed burst never ends.
            if (req_oth_s) begin
              state_d = serve_state(~own_side_s);
              cnt_d   = CNT_ZERO;
              last_d  = own_side_s;
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // FSM state and registered grant/select outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      last_q  <= SEL_B;
      sel_q   <= SEL_A;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_a_q <= (state_d == ST_SERVE_A);
      gnt_b_q <= (state_d == ST_SERVE_B);
      if (state_d == ST_SERVE_B) begin
        sel_q <= SEL_B;
      end else if (state_d == ST_SERVE_A) begin
        sel_q <= SEL_A;
      end else begin
        sel_q <= sel_q;
      end
    end
  end

  mux21_w #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel_i (sel_q),
    .a_i   (bus.data_a),
    .b_i   (bus.data_b),
    .y_o   (bus.out_data)
  );

  assign bus.out_valid = out_valid_s;
  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.sel       = sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed and random checks of mux2_rr_arbiter against a transfer scoreboard.
module tb_mux2_rr_arbiter;

  localparam int WIDTH     = 4;
  localparam int MAX_BURST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux2_rr_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       s;
    logic [3:0] d;
  } xfer_t;

  int         checks = 0;
  int         errors = 0;
  xfer_t      exp_q[$];
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  xfer_t      mon_e;
  logic [3:0] mon_d;
  logic       mon_s;
  logic       mon_oth;
  bit         rnd_mode = 1'b0;
  bit         ack_a    = 1'b0;
  bit         ack_b    = 1'b0;
  int         run_len  = 0;
  logic       run_side = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic s, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{s: s, d: d});
  endtask

  // Transfer monitor: a transfer at the next rising edge is visible at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rnd_mode && !(run_side ? bus.gnt_b : bus.gnt_a)) run_len = 0;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (!rnd_mode) begin
          chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("xfer_sel", 32'(bus.sel), 32'(mon_e.s));
            chk("xfer_data", 32'(bus.out_data), 32'(mon_e.d));
          end
        end else begin
          if (bus.gnt_a) begin
            chk("rnd_a_pending", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
              mon_d = qa.pop_front();
              chk("rnd_data_a", 32'(bus.out_data), 32'(mon_d));
            end
            chk("rnd_sel_a", 32'(bus.sel), 32'd0);
            ack_a   = 1'b1;
            mon_s   = 1'b0;
            mon_oth = bus.req_b;
          end else begin
            chk("rnd_b_pending", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
              mon_d = qb.pop_front();
              chk("rnd_data_b", 32'(bus.out_data), 32'(mon_d));
            end
            chk("rnd_sel_b", 32'(bus.sel), 32'd1);
            ack_b   = 1'b1;
            mon_s   = 1'b1;
            mon_oth = bus.req_a;
          end
          if (mon_oth) begin
            if (run_side == mon_s && run_len > 0) run_len++;
            else run_len = 1;
            run_side = mon_s;
            chk("burst_bound", 32'(run_len <= MAX_BURST), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus.data_a = 4'd0; bus.data_b = 4'd0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt_a", 32'(bus.gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(bus.gnt_b), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Tie from reset: A x4, B x4, A x4 back to back.
    bus.req_a = 1'b1; bus.data_a = 4'b1001;
    bus.req_b = 1'b1; bus.data_b = 4'b1011;
    bus.out_ready = 1'b1;
    push(1'b0, 4'b1001, 4); push(1'b1, 4'b1011, 4); push(1'b0, 4'b1001, 4);
    #1;
    chk("tie_latency_gnt", 32'(bus.gnt_a | bus.gnt_b), 32'd0);
    chk("tie_latency_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("tie_first_gnt_a", 32'(bus.gnt_a), 32'd1);
    repeat (12) tick();
    chk("tie_then_gnt_b", 32'(bus.gnt_b), 32'd1);
    chk("tie_all_done", 32'(exp_q.size()), 32'd0);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    #1 chk("tie_drop_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("tie_idle_gnt", 32'(bus.gnt_a | bus.gnt_b), 32'd0);
    chk("tie_idle_sel_hold", 32'(bus.sel), 32'd1);

    // Single requester: uncontended burst of 10.
    bus.req_a = 1'b1; bus.data_a = 4'b0110;
    push(1'b0, 4'b0110, 10);
    #1 chk("single_latency", 32'(bus.gnt_a), 32'd0);
    tick();
    chk("single_gnt_a", 32'(bus.gnt_a), 32'd1);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data", 32'(bus.out_data), 32'b0110);
    repeat (10) tick();
    chk("single_no_switch", 32'(bus.gnt_a), 32'd1);
    chk("single_all_done", 32'(exp_q.size()), 32'd0);
    bus.req_a = 1'b0;
    tick();
    chk("single_idle", 32'(bus.gnt_a), 32'd0);

    // Backpressure in SERVE_A with B waiting.
    bus.req_a = 1'b1; bus.data_a = 4'b1011;
    push(1'b0, 4'b1011, 4); push(1'b1, 4'b0101, 4);
    tick();
    bus.req_b = 1'b1; bus.data_b = 4'b0101;
    tick(); tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_gnt_a", 32'(bus.gnt_a), 32'd1);
      chk("bp_data", 32'(bus.out_data), 32'b1011);
    end
    chk("bp_pending", 32'(exp_q.size()), 32'd6);
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk("bp_back_to_a", 32'(bus.gnt_a), 32'd1);
    chk("bp_all_done", 32'(exp_q.size()), 32'd0);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick();

    // Early release in SERVE_B with A waiting, then a fresh contended burst for A.
    bus.req_b = 1'b1; bus.data_b = 4'b1100;
    push(1'b1, 4'b1100, 2);
    tick(); tick(); tick();
    bus.req_b = 1'b0; bus.req_a = 1'b1; bus.data_a = 4'b0011;
    #1 chk("rel_drop_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("rel_gnt_a", 32'(bus.gnt_a), 32'd1);
    chk("rel_sel", 32'(bus.sel), 32'd0);
    bus.req_b = 1'b1;
    push(1'b0, 4'b0011, 4); push(1'b1, 4'b1100, 1);
    repeat (5) tick();
    chk("rel_count_reset", 32'(bus.gnt_b), 32'd1);
    chk("rel_all_done", 32'(exp_q.size()), 32'd0);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick();

    // Early release in SERVE_B with nobody waiting.
    bus.req_b = 1'b1;
    push(1'b1, 4'b1100, 2);
    tick(); tick(); tick();
    bus.req_b = 1'b0;
    #1 chk("rel2_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("rel2_idle", 32'(bus.gnt_a | bus.gnt_b), 32'd0);
    chk("rel2_sel_hold", 32'(bus.sel), 32'd1);
    chk("rel2_all_done", 32'(exp_q.size()), 32'd0);

    // B rises on A's final burst transfer.
    bus.req_a = 1'b1; bus.data_a = 4'b0110;
    push(1'b0, 4'b0110, 4); push(1'b1, 4'b1001, 1);
    tick();
    repeat (3) tick();
    bus.req_b = 1'b1; bus.data_b = 4'b1001;
    tick();
    chk("sim_gnt_b", 32'(bus.gnt_b), 32'd1);
    tick();
    chk("sim_all_done", 32'(exp_q.size()), 32'd0);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick();

    // Asynchronous reset in the middle of a B burst.
    bus.req_b = 1'b1; bus.data_b = 4'b0101;
    push(1'b1, 4'b0101, 1);
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_gnt_a", 32'(bus.gnt_a), 32'd0);
    chk("arst_gnt_b", 32'(bus.gnt_b), 32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_sel", 32'(bus.sel), 32'd0);
    chk("arst_done", 32'(exp_q.size()), 32'd0);
    bus.req_b = 1'b0;
    #4 rst_n = 1'b1;
    tick();

    // Random traffic: every presented word must appear exactly once, in order.
    ack_a = 1'b0; ack_b = 1'b0; run_len = 0;
    rnd_mode = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (!bus.req_a || ack_a) begin
        if ($urandom_range(0, 2) != 0) begin
          bus.req_a = 1'b1; bus.data_a = 4'($urandom_range(0, 15)); qa.push_back(bus.data_a);
        end else begin
          bus.req_a = 1'b0;
        end
      end
      if (!bus.req_b || ack_b) begin
        if ($urandom_range(0, 2) != 0) begin
          bus.req_b = 1'b1; bus.data_b = 4'($urandom_range(0, 15)); qb.push_back(bus.data_b);
        end else begin
          bus.req_b = 1'b0;
        end
      end
      ack_a = 1'b0; ack_b = 1'b0;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && (bus.req_a || bus.req_b); c++) begin
      if (ack_a) bus.req_a = 1'b0;
      if (ack_b) bus.req_b = 1'b0;
      ack_a = 1'b0; ack_b = 1'b0;
      tick();
    end
    chk("drain_reqs_low", 32'(bus.req_a | bus.req_b), 32'd0);
    chk("drain_a_empty", 32'(qa.size()), 32'd0);
    chk("drain_b_empty", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
